// File: rtl/alu_vector_checker_if.sv
// Vector-memory read port and DUT drive/observe port of the ALU vector checker.
// master = checker side; slave = memory + DUT side.
interface alu_vector_checker_if #(
  parameter int IN_W   = 75,
  parameter int OUT_W  = 32,
  parameter int ADDR_W = 7
);
  logic                    mem_rd_en;
  logic [ADDR_W-1:0]       mem_addr;
  logic [IN_W+OUT_W-1:0]   mem_rdata;
  logic [IN_W-1:0]         dut_in;
  logic                    dut_valid;
  logic [OUT_W-1:0]        dut_out;

  modport master (
    output mem_rd_en, mem_addr, dut_in, dut_valid,
    input  mem_rdata, dut_out
  );

  modport slave (
    input  mem_rd_en, mem_addr, dut_in, dut_valid,
    output mem_rdata, dut_out
  );
endinterface

// File: rtl/alu_vector_checker.sv
// Fetches {stimulus, expected} vectors, drives the DUT and compares LATENCY cycles later; LATENCY+3 cycles/vector.
// No backpressure: memory answers one cycle after mem_rd_en; start is ignored while busy.
module alu_vector_checker #(
  parameter int IN_W         = 75,
  parameter int OUT_W        = 32,
  parameter int ADDR_W       = 7,
  parameter int LATENCY      = 1,
  parameter int STOP_ON_FAIL = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_W:0]      num_vectors,
  alu_vector_checker_if.master vec,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ADDR_W:0]      vec_count,
  output logic [ADDR_W:0]      fail_count,
  output logic [ADDR_W-1:0]    fail_index,
  output logic [OUT_W-1:0]     fail_expected,
  output logic [OUT_W-1:0]     fail_actual
);
  localparam int CW = $clog2(LATENCY + 1);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, SETTLE, CHECK, DONE} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  idx_q;
  logic [ADDR_W:0]    num_q;
  logic [ADDR_W:0]    idx_p1;
  logic [OUT_W-1:0]   expected_q;
  logic [IN_W-1:0]    dut_in_q;
  logic               dut_valid_q;
  logic [CW-1:0]      wait_q;
  logic               accept;
  logic               mismatch;

  assign accept   = start && (state_q == IDLE || state_q == DONE);
  assign mismatch = (vec.dut_out != expected_q);
  assign idx_p1   = {1'b0, idx_q} + (ADDR_W+1)'(1);

  assign vec.mem_rd_en = (state_q == FETCH);
  assign vec.mem_addr  = idx_q;
  assign vec.dut_in    = dut_in_q;
  assign vec.dut_valid = dut_valid_q;

  assign busy = (state_q == FETCH) || (state_q == LOAD) ||
                (state_q == SETTLE) || (state_q == CHECK);
  assign done = (state_q == DONE);
  assign pass = done && (fail_count == '0);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = (num_vectors == '0) ? DONE : FETCH;
      FETCH:      state_d = LOAD;
      LOAD:       state_d = SETTLE;
      SETTLE:     if (wait_q == CW'(1)) state_d = CHECK;
      CHECK: begin
        if ((mismatch && STOP_ON_FAIL != 0) || idx_p1 == num_q) state_d = DONE;
        else                                                      state_d = FETCH;
      end
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q         <= '0;
      num_q         <= '0;
      expected_q    <= '0;
      dut_in_q      <= '0;
      dut_valid_q   <= 1'b0;
      wait_q        <= '0;
      vec_count     <= '0;
      fail_count    <= '0;
      fail_index    <= '0;
      fail_expected <= '0;
      fail_actual   <= '0;
    end else begin
      if (accept) begin
        num_q         <= num_vectors;
        idx_q         <= '0;
        vec_count     <= '0;
        fail_count    <= '0;
        fail_index    <= '0;
        fail_expected <= '0;
        fail_actual   <= '0;
      end
      if (state_q == LOAD) begin
        dut_in_q    <= vec.mem_rdata[IN_W+OUT_W-1:OUT_W];
        expected_q  <= vec.mem_rdata[OUT_W-1:0];
        dut_valid_q <= 1'b1;
        wait_q      <= CW'(LATENCY);
      end
      if (state_q == SETTLE) wait_q <= wait_q - CW'(1);
      if (state_q == CHECK) begin
        vec_count <= vec_count + (ADDR_W+1)'(1);
        if (mismatch) begin
          fail_count <= fail_count + (ADDR_W+1)'(1);
          // Only the first failure is kept so the root cause is not overwritten.
          if (fail_count == '0) begin
            fail_index    <= idx_q;
            fail_expected <= expected_q;
            fail_actual   <= vec.dut_out;
          end
        end
        if (state_d == FETCH) idx_q <= idx_p1[ADDR_W-1:0];
      end
      if (state_d == DONE) dut_valid_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_vector_checker.sv
// Four checker instances (stop/continue, latency 1/3, and a latency-1 checker on a 3-stage DUT)
// driven with directed and random vector sets, scored against a vector-level reference model.
module tb_alu_vector_checker;
  localparam int IN_W = 75, OUT_W = 32, ADDR_W = 7, W = IN_W + OUT_W;
  localparam logic [3:0] ADD = 4'b0000, SUB = 4'b0001, SRA = 4'b1011, XOR = 4'b1000;

  typedef struct {
    int vc; int fc; int fidx;
    logic [31:0] fexp; logic [31:0] fact;
    logic pass;
  } exp_t;

  logic clk = 1'b0, rst;
  logic [3:0] start_s, busy_s, done_s, pass_s, rd_en_s, dv_s;
  logic [ADDR_W:0]   num_s [4];
  logic [ADDR_W:0]   vc_s [4];
  logic [ADDR_W:0]   fc_s [4];
  logic [ADDR_W-1:0] fidx_s [4];
  logic [ADDR_W-1:0] addr_s [4];
  logic [31:0]       fexp_s [4];
  logic [31:0]       fact_s [4];
  logic [IN_W-1:0]   din_s [4];
  logic [W-1:0]      mem [4][128];
  logic [IN_W-1:0]   last_stim [4];
  exp_t              sbq [4][$];
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  function automatic int lat_of(input int g); return (g == 2) ? 3 : 1; endfunction
  function automatic int stop_of(input int g); return (g == 0 || g == 2) ? 1 : 0; endfunction

  // Reference RV32 ALU: opcode[74:68] funct3[67:65] alt[64] A[63:32] B[31:0].
  function automatic logic [31:0] alu_f(input logic [IN_W-1:0] s);
    logic [31:0] a, b;
    a = s[63:32]; b = s[31:0];
    case (s[67:65])
      3'd0:    return s[64] ? a - b : a + b;
      3'd1:    return a << b[4:0];
      3'd2:    return {31'd0, $signed(a) < $signed(b)};
      3'd3:    return {31'd0, a < b};
      3'd4:    return a ^ b;
      3'd5:    return s[64] ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : g_inst
    alu_vector_checker_if #(.IN_W(IN_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W)) bus ();

    alu_vector_checker #(
      .IN_W(IN_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W),
      .LATENCY(lat_of(g)), .STOP_ON_FAIL(stop_of(g))
    ) u_dut (
      .clk(clk), .rst(rst), .start(start_s[g]), .num_vectors(num_s[g]), .vec(bus.master),
      .busy(busy_s[g]), .done(done_s[g]), .pass(pass_s[g]),
      .vec_count(vc_s[g]), .fail_count(fc_s[g]), .fail_index(fidx_s[g]),
      .fail_expected(fexp_s[g]), .fail_actual(fact_s[g])
    );

    assign rd_en_s[g] = bus.mem_rd_en;
    assign addr_s[g]  = bus.mem_addr;
    assign din_s[g]   = bus.dut_in;
    assign dv_s[g]    = bus.dut_valid;

    always_ff @(posedge clk) if (bus.mem_rd_en) bus.mem_rdata <= mem[g][bus.mem_addr];

    if (g >= 2) begin : g_pipe
      logic [31:0] p1, p2, p3;
      always_ff @(posedge clk) begin
        if (rst) begin p1 <= '0; p2 <= '0; p3 <= '0; end
        else begin p1 <= alu_f(bus.dut_in); p2 <= p1; p3 <= p2; end
      end
      assign bus.dut_out = p3;
    end else begin : g_comb
      assign bus.dut_out = alu_f(bus.dut_in);
    end

    initial begin : mon
      exp_t e;
      int rc;
      bit armed;
      rc = 0; armed = 0;
      forever begin
        @(negedge clk); #1;
        if (rst) begin
          rc = 0; armed = 0;
        end else begin
          if (armed && done_s[g]) begin
            armed = 0;
            if (sbq[g].size() == 0) begin
              total++; bad++;
              $display("FAIL sb_underflow%0d: got done with no expected entry", g);
            end else begin
              e = sbq[g].pop_front();
              check($sformatf("vec_count%0d", g), vc_s[g], e.vc);
              check($sformatf("fail_count%0d", g), fc_s[g], e.fc);
              check($sformatf("pass%0d", g), pass_s[g], e.pass);
              check($sformatf("fail_index%0d", g), fidx_s[g], e.fidx);
              check($sformatf("fail_expected%0d", g), fexp_s[g], e.fexp);
              check($sformatf("fail_actual%0d", g), fact_s[g], e.fact);
              check($sformatf("reads%0d", g), rc, e.vc);
            end
          end
          if (start_s[g] && !busy_s[g]) begin rc = 0; armed = 1; end
          if (rd_en_s[g]) begin
            check($sformatf("fetch_addr%0d", g), addr_s[g], rc);
            rc++;
          end
        end
      end
    end
  end

  task automatic setv(input int g, input int i, input logic [3:0] op,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
    mem[g][i] = {7'h33, op, a, b, e};
  endtask

  task automatic rst_check(input int g);
    check($sformatf("rst_ctl%0d", g), {busy_s[g], done_s[g], pass_s[g], rd_en_s[g], dv_s[g]}, 0);
    check($sformatf("rst_cnt%0d", g), {vc_s[g], fc_s[g], fidx_s[g]}, 0);
    check($sformatf("rst_fail%0d", g), {fexp_s[g], fact_s[g]}, 0);
    check($sformatf("rst_dut%0d", g), {addr_s[g], din_s[g]}, 0);
  endtask

  // Model: walk the vector list, decide mismatches, then launch the run and time it.
  task automatic run(input int g, input int n, input bit poke);
    exp_t e;
    int cyc, lim;
    logic [IN_W-1:0] prev, s;
    logic [31:0] act, ex;
    e.vc = 0; e.fc = 0; e.fidx = 0; e.fexp = '0; e.fact = '0; e.pass = 1'b1;
    prev = last_stim[g];
    for (int i = 0; i < n; i++) begin
      s  = mem[g][i][W-1:32];
      ex = mem[g][i][31:0];
      // Instance 3 samples a 3-stage DUT one cycle after LOAD: it sees the previous stimulus' result.
      act = (g == 3) ? alu_f(prev) : alu_f(s);
      prev = s;
      e.vc++;
      if (act != ex) begin
        if (e.fc == 0) begin e.fidx = i; e.fexp = ex; e.fact = act; end
        e.fc++;
        e.pass = 1'b0;
        if (stop_of(g) != 0) break;
      end
    end
    last_stim[g] = prev;
    sbq[g].push_back(e);
    lim = e.vc * (lat_of(g) + 3) + 1;
    start_s[g] = 1'b1; num_s[g] = (ADDR_W+1)'(n);
    @(negedge clk);
    start_s[g] = 1'b0; cyc = 1;
    while (!done_s[g] && cyc < lim + 20) begin
      if (poke && cyc == 5) begin start_s[g] = 1'b1; num_s[g] = 1; end
      else start_s[g] = 1'b0;
      @(negedge clk); cyc++;
    end
    start_s[g] = 1'b0;
    check($sformatf("run_cycles%0d", g), cyc, lim);
    check($sformatf("dv_done%0d", g), dv_s[g], 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [IN_W-1:0] s;
    logic [31:0] ev;
    logic [2:0] f3;
    logic alt;
    int g, n, cyc;
    rst = 1'b1; start_s = '0;
    for (int k = 0; k < 4; k++) begin num_s[k] = '0; last_stim[k] = '0; end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) rst_check(k);
    rst = 1'b0;
    @(negedge clk);

    // All-pass, then stop at a corrupted vector 1, then a clean rerun with a start poked mid-run.
    setv(0, 0, ADD, 32'd5, 32'd3, 32'd8);
    setv(0, 1, SUB, 32'd0, 32'd1, 32'hFFFF_FFFF);
    setv(0, 2, SRA, 32'h8000_0000, 32'd4, 32'hF800_0000);
    run(0, 3, 1'b0);
    setv(0, 1, ADD, 32'd5, 32'd3, 32'd9);
    run(0, 3, 1'b0);
    setv(0, 1, ADD, 32'd5, 32'd3, 32'd8);
    run(0, 3, 1'b1);

    // Continue on fail with mismatches at 1 and 3, then an empty run.
    setv(1, 0, ADD, 32'd5, 32'd3, 32'd8);
    setv(1, 1, ADD, 32'd5, 32'd3, 32'd9);
    setv(1, 2, SRA, 32'h8000_0000, 32'd4, 32'hF800_0000);
    setv(1, 3, SUB, 32'd0, 32'd1, 32'd0);
    run(1, 4, 1'b0);
    run(1, 0, 1'b0);

    // Same vectors against a 3-stage DUT: correct latency passes, latency 1 fails.
    for (int k = 2; k < 4; k++) begin
      setv(k, 0, ADD, 32'd5, 32'd3, 32'd8);
      setv(k, 1, SUB, 32'd0, 32'd1, 32'hFFFF_FFFF);
      setv(k, 2, SRA, 32'h8000_0000, 32'd4, 32'hF800_0000);
      setv(k, 3, XOR, 32'hF0, 32'h0F, 32'hFF);
    end
    run(2, 4, 1'b0);
    run(3, 4, 1'b0);

    for (int it = 0; it < 24; it++) begin
      g = $urandom_range(0, 3);
      n = $urandom_range(1, 10);
      for (int i = 0; i < n; i++) begin
        f3  = 3'($urandom_range(0, 7));
        alt = (f3 == 3'd0 || f3 == 3'd5) ? 1'($urandom_range(0, 1)) : 1'b0;
        s   = {7'h33, f3, alt, 32'($urandom), 32'($urandom)};
        ev  = alu_f(s);
        if ($urandom_range(0, 3) == 0) ev = ev ^ (32'($urandom) | 32'd1);
        mem[g][i] = {s, ev};
      end
      run(g, n, 1'($urandom_range(0, 1)));
    end

    // Abort instance 2 during SETTLE of vector 2, then rerun from index 0.
    for (int i = 0; i < 5; i++) begin
      s = {7'h33, 4'b0000, 32'(i * 7 + 1), 32'(i + 100)};
      mem[2][i] = {s, alu_f(s)};
    end
    start_s[2] = 1'b1; num_s[2] = 5;
    @(negedge clk);
    start_s[2] = 1'b0; cyc = 0;
    while (!(rd_en_s[2] && addr_s[2] == 2) && cyc < 100) begin @(negedge clk); cyc++; end
    check("reach_vec2", {rd_en_s[2], addr_s[2]}, {1'b1, 7'd2});
    repeat (2) @(negedge clk);
    check("in_settle", {busy_s[2], rd_en_s[2], dv_s[2]}, 3'b101);
    rst = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) rst_check(k);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) last_stim[k] = '0;
    @(negedge clk);
    run(2, 5, 1'b0);

    repeat (3) @(negedge clk);
    check("sb_drained", sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
